// File: rtl/writeback_queue.sv
// Writeback queue: a small circular buffer of (register, data) writebacks
// that drains into one register-file write port. Pending entries can be
// looked up by two read ports so that the youngest pending value is
// forwarded ahead of the register file.
//
// Handshakes use strict valid/ready semantics. On the input side a
// writeback transfers at a rising edge when inValid and inReady are both 1.
// inReady depends only on occupancy, never on outReady.
// On the output side an entry retires at a rising edge when
// outWriteEnable, which is (count != 0) && outReady, is 1.
// Writebacks to register 0 complete the handshake but are dropped.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [4:0]               inReg,
    input  logic [31:0]              inData,
    input  logic                     outReady,
    output logic                     outWriteEnable,
    output logic [4:0]               outWriteReg,
    output logic [31:0]              outWriteData,
    input  logic [4:0]               lookupReg1,
    input  logic [4:0]               lookupReg2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [31:0]              fwdData1,
    output logic [31:0]              fwdData2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic          w_not_empty;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_slot_idx   [DEPTH];
    logic          w_slot_valid [DEPTH];

    assign w_not_empty = (r_count != '0);
    assign inReady     = (r_count < CW'(DEPTH));
    // Register-0 writebacks are accepted but never stored.
    assign w_push      = inValid && inReady && (inReg != 5'd0);
    assign w_pop       = outWriteEnable;

    assign outWriteEnable = w_not_empty && outReady;
    assign outWriteReg    = w_not_empty ? r_reg[r_head]  : 5'd0;
    assign outWriteData   = w_not_empty ? r_data[r_head] : 32'd0;
    assign count          = r_count;

    // Slot k is the entry of age k counted from the head (oldest = 0).
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        assign w_slot_idx[k]   = r_head + PW'(k);
        assign w_slot_valid[k] = (CW'(k) < r_count);
    end

    // Pointer and occupancy update; reset discards every pending entry.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is not reset; validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg[r_tail]  <= inReg;
            r_data[r_tail] <= inData;
        end
    end

    // Forwarding lookup over stored entries only, scanning oldest to
    // youngest so the youngest match wins; the head being popped still counts.
    always_comb begin
        hit1     = 1'b0;
        fwdData1 = 32'd0;
        hit2     = 1'b0;
        fwdData2 = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_slot_valid[k] && (lookupReg1 != 5'd0) &&
                (r_reg[w_slot_idx[k]] == lookupReg1)) begin
                hit1     = 1'b1;
                fwdData1 = r_data[w_slot_idx[k]];
            end
            if (w_slot_valid[k] && (lookupReg2 != 5'd0) &&
                (r_reg[w_slot_idx[k]] == lookupReg2)) begin
                hit2     = 1'b1;
                fwdData2 = r_data[w_slot_idx[k]];
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue (DEPTH = 4): a directed vector table followed by
// hand-written sequences for fill/wrap and asynchronous reset.
module tb_writeback_queue;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inReg;
    logic [31:0] inData;
    logic        outReady;
    logic        outWriteEnable;
    logic [4:0]  outWriteReg;
    logic [31:0] outWriteData;
    logic [4:0]  lookupReg1;
    logic [4:0]  lookupReg2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwdData1;
    logic [31:0] fwdData2;
    logic [2:0]  count;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .rstN           (rstN),
        .inValid        (inValid),
        .inReady        (inReady),
        .inReg          (inReg),
        .inData         (inData),
        .outReady       (outReady),
        .outWriteEnable (outWriteEnable),
        .outWriteReg    (outWriteReg),
        .outWriteData   (outWriteData),
        .lookupReg1     (lookupReg1),
        .lookupReg2     (lookupReg2),
        .hit1           (hit1),
        .hit2           (hit2),
        .fwdData1       (fwdData1),
        .fwdData2       (fwdData2),
        .count          (count)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        iv;
        logic [4:0]  ir;
        logic [31:0] id;
        logic        ordy;
        logic [4:0]  l1;
        logic [4:0]  l2;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic        e_h1;
        logic [31:0] e_f1;
        logic        e_h2;
        logic [31:0] e_f2;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic iv, input logic [4:0] ir, input logic [31:0] id,
                           input logic ordy, input logic [4:0] l1, input logic [4:0] l2,
                           input logic e_rdy, input logic e_we, input logic [4:0] e_wreg,
                           input logic [31:0] e_wdata, input logic e_h1, input logic [31:0] e_f1,
                           input logic e_h2, input logic [31:0] e_f2, input logic [2:0] e_cnt);
        vec_t v;
        v.iv = iv; v.ir = ir; v.id = id; v.ordy = ordy; v.l1 = l1; v.l2 = l2;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_wreg = e_wreg; v.e_wdata = e_wdata;
        v.e_h1 = e_h1; v.e_f1 = e_f1; v.e_h2 = e_h2; v.e_f2 = e_f2; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    // ---------------- driver ----------------
    // Inputs change just after the falling edge; outputs are sampled 2 time
    // units later, well before the next rising edge.
    task automatic drive(input logic iv, input logic [4:0] ir, input logic [31:0] id,
                         input logic ordy, input logic [4:0] l1, input logic [4:0] l2);
        @(negedge clk);
        inValid = iv; inReg = ir; inData = id; outReady = ordy;
        lookupReg1 = l1; lookupReg2 = l2;
        #2;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".we"},    32'(outWriteEnable), 32'd0);
        check({tag, ".wreg"},  32'(outWriteReg),    32'd0);
        check({tag, ".wdata"}, outWriteData,        32'd0);
        check({tag, ".hit1"},  32'(hit1),           32'd0);
        check({tag, ".fwd1"},  fwdData1,            32'd0);
        check({tag, ".rdy"},   32'(inReady),        32'd1);
        check({tag, ".count"}, 32'(count),          32'd0);
    endtask

    // ---------------- scoreboard for the fill/wrap run ----------------
    logic [36:0] exp_q[$];

    initial begin
        string tag;
        int    pushed;
        int    popped;
        int    mcnt;
        int    cycles;
        logic  drain_on;
        logic  m_push;
        logic  m_pop;
        logic [36:0] e;

        rstN = 1'b0; inValid = 1'b0; inReg = '0; inData = '0; outReady = 1'b0;
        lookupReg1 = '0; lookupReg2 = '0;

        // reset state, held across a rising edge
        @(negedge clk);
        lookupReg1 = 5'd5;
        outReady   = 1'b1;
        #2;
        check_idle("reset");
        @(negedge clk);
        rstN = 1'b1;

        // table: first push, forwarding, drop of reg 0, same-reg drain, push+pop
        //       iv ir    id           ordy l1 l2  rdy we wreg wdata        h1 f1           h2 f2      cnt
        add_vec(1, 5'd5, 32'hAAAA0001, 0, 5, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
        add_vec(0, 5'd0, 32'h0,        0, 5, 3,  1, 0, 5, 32'hAAAA0001, 1, 32'hAAAA0001, 0, 32'h0,   1);
        add_vec(0, 5'd0, 32'h0,        1, 5, 0,  1, 1, 5, 32'hAAAA0001, 1, 32'hAAAA0001, 0, 32'h0,   1);
        add_vec(1, 5'd0, 32'hDEADBEEF, 1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
        add_vec(0, 5'd0, 32'h0,        1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
        add_vec(1, 5'd7, 32'h11,       0, 7, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
        add_vec(1, 5'd7, 32'h22,       0, 7, 5,  1, 0, 7, 32'h11,       1, 32'h11,       0, 32'h0,   1);
        add_vec(1, 5'd7, 32'h33,       0, 7, 0,  1, 0, 7, 32'h11,       1, 32'h22,       0, 32'h0,   2);
        add_vec(0, 5'd0, 32'h0,        0, 7, 7,  1, 0, 7, 32'h11,       1, 32'h33,       1, 32'h33,  3);
        add_vec(0, 5'd0, 32'h0,        1, 7, 0,  1, 1, 7, 32'h11,       1, 32'h33,       0, 32'h0,   3);
        add_vec(0, 5'd0, 32'h0,        1, 7, 0,  1, 1, 7, 32'h22,       1, 32'h33,       0, 32'h0,   2);
        add_vec(0, 5'd0, 32'h0,        1, 7, 0,  1, 1, 7, 32'h33,       1, 32'h33,       0, 32'h0,   1);
        add_vec(0, 5'd0, 32'h0,        1, 7, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
        add_vec(1, 5'd3, 32'h300,      1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);
        add_vec(1, 5'd4, 32'h400,      1, 3, 4,  1, 1, 3, 32'h300,      1, 32'h300,      0, 32'h0,   1);
        add_vec(0, 5'd0, 32'h0,        0, 3, 4,  1, 0, 4, 32'h400,      0, 32'h0,        1, 32'h400, 1);
        add_vec(0, 5'd0, 32'h0,        1, 0, 0,  1, 1, 4, 32'h400,      0, 32'h0,        0, 32'h0,   1);
        add_vec(0, 5'd0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,   0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].iv, vq[i].ir, vq[i].id, vq[i].ordy, vq[i].l1, vq[i].l2);
            tag = $sformatf("v%0d", i);
            check({tag, ".rdy"},   32'(inReady),        32'(vq[i].e_rdy));
            check({tag, ".we"},    32'(outWriteEnable), 32'(vq[i].e_we));
            check({tag, ".wreg"},  32'(outWriteReg),    32'(vq[i].e_wreg));
            check({tag, ".wdata"}, outWriteData,        vq[i].e_wdata);
            check({tag, ".hit1"},  32'(hit1),           32'(vq[i].e_h1));
            check({tag, ".fwd1"},  fwdData1,            vq[i].e_f1);
            check({tag, ".hit2"},  32'(hit2),           32'(vq[i].e_h2));
            check({tag, ".fwd2"},  fwdData2,            vq[i].e_f2);
            check({tag, ".count"}, 32'(count),          32'(vq[i].e_cnt));
        end

        // fill to full, then steady push/pop across pointer wrap for 10 entries
        pushed = 0; popped = 0; mcnt = 0; cycles = 0; drain_on = 1'b0;
        while ((pushed < 10 || mcnt != 0) && cycles < 80) begin
            drive(pushed < 10, 5'(pushed + 1), 32'h1000 + 32'(pushed), drain_on, 0, 0);
            cycles++;
            check($sformatf("fill%0d.rdy", cycles),   32'(inReady),        32'(mcnt < 4));
            check($sformatf("fill%0d.count", cycles), 32'(count),          32'(mcnt));
            m_pop  = (mcnt != 0) && drain_on;
            m_push = (pushed < 10) && (mcnt < 4);
            check($sformatf("fill%0d.we", cycles),    32'(outWriteEnable), 32'(m_pop));
            if (m_pop) begin
                e = exp_q.pop_front();
                check($sformatf("fill%0d.wreg", cycles),  32'(outWriteReg), 32'(e[36:32]));
                check($sformatf("fill%0d.wdata", cycles), outWriteData,     e[31:0]);
                popped++;
            end
            if (m_push) begin
                exp_q.push_back({5'(pushed + 1), 32'h1000 + 32'(pushed)});
                pushed++;
            end
            mcnt = mcnt + int'(m_push) - int'(m_pop);
            if (mcnt == 4) drain_on = 1'b1;
        end
        check("fill.timeout", 32'(cycles < 80), 32'd1);
        check("fill.popped", 32'(popped), 32'd10);

        // three entries pending, then asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(11 + i), 32'hB0 + 32'(i), 0, 0, 0);
            check($sformatf("pre%0d.count", i), 32'(count), 32'(i));
        end
        drive(0, 0, 0, 1, 11, 0);
        check("pre.count", 32'(count), 32'd3);
        check("pre.we", 32'(outWriteEnable), 32'd1);
        check("pre.hit1", 32'(hit1), 32'd1);
        #1 rstN = 1'b0;
        #1;
        check_idle("async");
        @(negedge clk);
        #1;
        check_idle("inrst");
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 11, 12);
            check_idle($sformatf("post%0d", i));
            check($sformatf("post%0d.hit2", i), 32'(hit2), 32'd0);
        end

        // normal operation after reset
        drive(1, 5'd9, 32'h9, 0, 9, 0);
        check("r9.push.count", 32'(count), 32'd0);
        drive(0, 0, 0, 1, 9, 0);
        check("r9.count", 32'(count),          32'd1);
        check("r9.we",    32'(outWriteEnable), 32'd1);
        check("r9.wreg",  32'(outWriteReg),    32'd9);
        check("r9.wdata", outWriteData,        32'h9);
        check("r9.hit1",  32'(hit1),           32'd1);
        check("r9.fwd1",  fwdData1,            32'h9);
        drive(0, 0, 0, 1, 9, 0);
        check_idle("r9.done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
